// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL lock qualification, hold-off and triplicated downstream reset release
module pll_lock_sequencer #(
    parameter int LOCK_COUNT   = 64,
    parameter int UNLOCK_COUNT = 4,
    parameter int HOLDOFF      = 16,
    parameter int TIMEOUT      = 4096,
    parameter int CNT_W        = 13
) (
    input  logic       clk_40MHz,
    input  logic       rst_b,
    input  logic       enable,
    input  logic       instLock,
    input  logic       relock,
    input  logic       clearStatus,
    output logic       pllLocked,
    output logic       rstOutA_b,
    output logic       rstOutB_b,
    output logic       rstOutC_b,
    output logic [7:0] lossCount,
    output logic       lockTimeout,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        sIdle     = 2'd0,
        sWaitLock = 2'd1,
        sHoldoff  = 2'd2,
        sLocked   = 2'd3
    } stateT;

    // Terminal values: an event fires on the edge where the counter sits at N-1
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_COUNT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    stateT            curState, nextState;
    logic             lockMeta, lockS;
    logic [CNT_W-1:0] runCnt, runNext;
    logic [CNT_W-1:0] holdCnt, holdNext;
    logic [CNT_W-1:0] unlockCnt, unlockNext;
    logic [CNT_W-1:0] toCnt, toNext;
    logic             lossEvent, timeoutEvent;
    logic [7:0]       lossBase, lossNext;
    logic             timeoutNext;

    assign state = curState;

    // Two-flop synchronizer bringing the PLL's raw lock indication into clk_40MHz
    always_ff @(posedge clk_40MHz or negedge rst_b) begin
        if (!rst_b) begin
            lockMeta <= 1'b0;
            lockS    <= 1'b0;
        end else begin
            lockMeta <= instLock;
            lockS    <= lockMeta;
        end
    end

    // Next-state, counter and status-event decode; enable beats relock beats normal flow
    always_comb begin
        nextState    = curState;
        runNext      = runCnt;
        holdNext     = holdCnt;
        unlockNext   = unlockCnt;
        toNext       = toCnt;
        lossEvent    = 1'b0;
        timeoutEvent = 1'b0;
        if (!enable) begin
            nextState  = sIdle;
            runNext    = '0;
            holdNext   = '0;
            unlockNext = '0;
            toNext     = '0;
        end else if (relock && curState != sIdle) begin
            nextState  = sWaitLock;
            runNext    = '0;
            holdNext   = '0;
            unlockNext = '0;
            toNext     = '0;
        end else begin
            case (curState)
                sIdle: nextState = sWaitLock;
                sWaitLock: begin
                    if (toCnt == TO_LAST) begin
                        timeoutEvent = 1'b1;
                        toNext       = '0;
                    end else begin
                        toNext = toCnt + CNT_ONE;
                    end
                    if (!lockS) begin
                        runNext = '0;
                    end else if (runCnt == LOCK_LAST) begin
                        nextState = sHoldoff;
                        runNext   = '0;
                        toNext    = '0;
                    end else begin
                        runNext = runCnt + CNT_ONE;
                    end
                end
                sHoldoff: begin
                    if (!lockS) begin
                        nextState = sWaitLock;
                        holdNext  = '0;
                    end else if (holdCnt == HOLD_LAST) begin
                        nextState = sLocked;
                        holdNext  = '0;
                    end else begin
                        holdNext = holdCnt + CNT_ONE;
                    end
                end
                sLocked: begin
                    if (lockS) begin
                        unlockNext = '0;
                    end else if (unlockCnt == UNLOCK_LAST) begin
                        nextState  = sWaitLock;
                        unlockNext = '0;
                        lossEvent  = 1'b1;
                    end else begin
                        unlockNext = unlockCnt + CNT_ONE;
                    end
                end
                default: nextState = sIdle;
            endcase
        end
        // A clear coinciding with an event still records the event
        lossBase    = clearStatus ? 8'd0 : lossCount;
        lossNext    = (lossEvent && lossBase != 8'hFF) ? lossBase + 8'd1 : lossBase;
        timeoutNext = timeoutEvent | (lockTimeout & ~clearStatus);
    end

    // State, counters and registered outputs; outputs are decoded from the next state
    always_ff @(posedge clk_40MHz or negedge rst_b) begin
        if (!rst_b) begin
            curState    <= sIdle;
            runCnt      <= '0;
            holdCnt     <= '0;
            unlockCnt   <= '0;
            toCnt       <= '0;
            pllLocked   <= 1'b0;
            rstOutA_b   <= 1'b0;
            rstOutB_b   <= 1'b0;
            rstOutC_b   <= 1'b0;
            lossCount   <= 8'd0;
            lockTimeout <= 1'b0;
        end else begin
            curState    <= nextState;
            runCnt      <= runNext;
            holdCnt     <= holdNext;
            unlockCnt   <= unlockNext;
            toCnt       <= toNext;
            pllLocked   <= (nextState == sHoldoff) || (nextState == sLocked);
            rstOutA_b   <= (nextState == sLocked);
            rstOutB_b   <= (nextState == sLocked);
            rstOutC_b   <= (nextState == sLocked);
            lossCount   <= lossNext;
            lockTimeout <= timeoutNext;
        end
    end

endmodule
